// File: rtl/stream_mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer: selection modes
// and the channel-index width helper.
package stream_mux_pkg;

  localparam logic [1:0] MODE_MANUAL = 2'd0;
  localparam logic [1:0] MODE_FIXED  = 2'd1;
  localparam logic [1:0] MODE_RR     = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  function automatic int chan_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant selection for the stream mux: manual, fixed priority
// or round-robin starting at ptr.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int CW   = chan_width(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CW-1:0]   ptr,
  input  logic [1:0]      mode,
  input  logic [CW-1:0]   sel,
  output logic            gnt_valid,
  output logic [CW-1:0]   gnt_idx
);

  always_comb begin
    int idx;
    idx       = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    case (mode)
      MODE_MANUAL: begin
        // Compare against each legal index so an out-of-range sel never grants.
        for (int i = 0; i < N_CH; i++) begin
          if ((sel == CW'(i)) && req[i]) begin
            gnt_valid = 1'b1;
            gnt_idx   = CW'(i);
          end
        end
      end
      MODE_FIXED: begin
        for (int i = N_CH - 1; i >= 0; i--) begin
          if (req[i]) begin
            gnt_valid = 1'b1;
            gnt_idx   = CW'(i);
          end
        end
      end
      MODE_RR: begin
        // Walk the search order backwards so the earliest hit is written last.
        for (int k = N_CH - 1; k >= 0; k--) begin
          idx = (int'(ptr) + k) % N_CH;
          if (req[idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = CW'(idx);
          end
        end
      end
      default: begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
      end
    endcase
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with one output register stage;
// each output beat carries the index of the channel it came from.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int N_CH = 4,
  parameter  int W    = 8,
  localparam int CW   = chan_width(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [CW-1:0]     sel,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH*W-1:0] in_data,
  output logic [N_CH-1:0]   in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [CW-1:0]     out_chan,
  input  logic              out_ready
);

  logic          gnt_valid;
  logic [CW-1:0] gnt_idx;
  logic [CW-1:0] ptr;
  logic [CW-1:0] ptr_next;
  logic          load_en;
  logic          in_xfer;
  logic          out_xfer;
  logic [W-1:0]  gnt_data;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .mode      (mode),
    .sel       (sel),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign load_en  = !out_valid || out_ready;
  assign in_xfer  = !rst && load_en && gnt_valid;
  assign out_xfer = out_valid && out_ready;
  assign ptr_next = (gnt_idx == CW'(N_CH - 1)) ? '0 : gnt_idx + CW'(1);

  always_comb begin
    in_ready = '0;
    if (in_xfer) in_ready[gnt_idx] = 1'b1;
  end

  // Only the granted slice is ever routed, so X on idle channels stays out.
  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt_idx == CW'(i)) gnt_data = in_data[i*W +: W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else begin
      if (in_xfer) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_chan  <= gnt_idx;
        if (mode == MODE_RR) ptr <= ptr_next;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
Parametrised N-channel, W-bit streaming multiplexer. It replaces the 2:1 combinational mux where sources are valid/ready streams. Three selection modes are supported: manual select, fixed priority and round-robin. One output register stage sits between the selected input and the single downstream consumer. Each output beat is tagged with the index of its source channel.

Parameters:
- N_CH, 4, number of input channels (≥2).
- W, 8, data width per channel.
- CW, $clog2(N_CH), derived local width of channel index. Not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- mode  in  2  selection mode: 0 manual, 1 fixed priority, 2 round-robin, 3 reserved.
- sel  in  CW  channel index used in manual mode.
- in_valid  in  N_CH  per-channel valid; bit i belongs to channel i.
- in_data  in  N_CH*W  packed data; channel i is bits [i*W +: W].
- in_ready  out  N_CH  per-channel ready; combinational; at most one bit high.
- out_valid  out  1  output register holds a beat.
- out_data  out  W  registered data.
- out_chan  out  CW  registered source channel of the held beat.
- out_ready  in  1  downstream accepts the beat.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, out_data=0, out_chan=0, rr pointer ptr=0.
  - in_ready forced to all-zero while rst=1.
  - Reset mid-transfer drops the held beat; no beat is emitted after release.
- Load enable: load_en = !out_valid || out_ready.
- Grant g is computed combinationally each cycle from mode, sel, in_valid and ptr:
  - Manual (0): g=sel if sel<N_CH and in_valid[sel]=1; otherwise no grant. Other channels are never granted.
  - Fixed (1): g = lowest index i with in_valid[i]=1.
  - Round-robin (2): g = first i with in_valid[i]=1, searching ptr, ptr+1, …, wrapping mod N_CH.
  - Reserved (3): no grant; in_ready all 0. The held beat still drains normally.
- Handshake:
  - in_ready[g]=1 only when load_en=1 and a grant exists. All other bits are 0.
  - Input transfer occurs on channel g when in_valid[g] && in_ready[g].
  - Output transfer occurs when out_valid && out_ready.
- Register update at the clock edge:
  - Input transfer: out_data<=in_data[g], out_chan<=g, out_valid<=1.
  - Output transfer without input transfer: out_valid<=0; out_data and out_chan hold.
  - Otherwise all registers hold.
- Latency and throughput:
  - 1 cycle from input acceptance to out_valid.
  - Sustained 1 beat/clock when out_ready is held at 1. A simultaneous drain and load is allowed.
- Backpressure: while out_valid=1 && out_ready=0, in_ready is all 0 and out_data/out_chan are stable.
- Round-robin pointer:
  - On an input transfer in mode 2, ptr <= (g+1) mod N_CH, wrapping from N_CH-1 to 0.
  - In other modes ptr holds.
- Mode or sel change: takes effect at the next arbitration; it never alters the held beat.
- in_data of non-granted channels is ignored. An X on a non-granted channel must not propagate to the outputs.

Decomposition:
- Package stream_mux_pkg holds:
  - Mode localparams MODE_MANUAL=2'd0, MODE_FIXED=2'd1, MODE_RR=2'd2, MODE_RSVD=2'd3.
  - A helper function computing CW.
- Sub-module rr_arbiter (params N_CH):
  - Inputs: req[N_CH], ptr[CW], mode, sel.
  - Outputs: gnt_valid, gnt_idx[CW].
  - Purely combinational.
- stream_mux_rr owns ptr, the output register and the handshake logic.

Test Plan:
(All scenarios use N_CH=4, W=8, in_data ch i = 8'hA0+i unless stated.)
1. Reset mid-stream: out_valid=1, out_ready=0, assert rst asynchronously between edges -> out_valid, out_data and out_chan go to 0 before the next edge; in_ready=4'b0000 while rst=1; after release, the first out_valid follows an accepted input.
2. Manual: mode=0, sel=2, in_valid=4'b1111, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA2, out_chan=2. With sel=2 and in_valid=4'b1011 -> in_ready=0 and no beat.
3. Fixed priority: mode=1, in_valid=4'b1010, out_ready=1 for 3 cycles -> out_chan=1 every cycle, out_data=8'hA1; channel 3 is never granted.
4. Round-robin fairness: mode=2, in_valid=4'b1111, out_ready=1 for 8 cycles after reset -> out_chan sequence 0,1,2,3,0,1,2,3 with no bubbles.
5. Round-robin skip and wrap: mode=2, ptr=1 via one ch0 transfer, then in_valid=4'b1001 -> out_chan sequence 3,0,3,0.
6. Backpressure: hold out_ready=0 for 3 cycles with out_valid=1 and out_data=8'hA0 -> in_ready=0 and out_data stable. Raise out_ready with in_valid[1]=1 -> same-cycle drain and load; next cycle out_data=8'hA1.
